frame_bus_bridge: RTL and testbench

- Parametrised bridge between the UART frame stream and the register bus. It supersedes the fixed 3-slave OR-combining and single-shot address decoding.
- Buffers incoming command frames in a FIFO and issues one register transaction at a time (address/data/valid) to NUM_SLAVES slaves.
- Waits for an ack with a timeout, then reports the outcome (read data, status) on a one-cycle response strobe.
- Sits between the UART receiver and the clock/UART/channel register slaves. Feeds the debug and seven-segment paths through its response outputs.

---
 rtl/frame_bus_bridge.sv | 160 ++++++++++++++++
 tb/tb_frame_bus_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bus_bridge.sv
// Bridge from the UART command-frame stream to the register bus. It buffers frames in a FIFO and
// runs one bus transaction at a time, finishing on an ack, an ack collision or a timeout.
module frame_bus_bridge #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_valid,
  input  logic [ADDR_W+DATA_W:0]       frame,
  input  logic [NUM_SLAVES-1:0]        ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] data_out,
  input  logic [NUM_SLAVES-1:0]        data_out_valid,
  output logic                         valid,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            data,
  output logic                         rd,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [1:0]                   rsp_err,
  output logic                         overflow,
  output logic                         busy
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_COLL    = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_next;

  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               empty, full, push, pop;

  logic [TMO_W-1:0]   tmo_cnt, tmo_next;
  logic [DATA_W-1:0]  rsp_data_next;
  logic [1:0]         rsp_err_next;
  logic               rsp_load;

  logic               ack_any, ack_multi, ack_one;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_dov;

  logic [FRAME_W-1:0] head;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push  = frame_valid && (!full || pop);
  assign head  = mem[rd_ptr];
  assign busy  = !empty || (state != S_IDLE);

  // ack is one-hot exactly when clearing its lowest set bit leaves nothing behind.
  assign ack_any   = |ack;
  assign ack_multi = |(ack & (ack - NUM_SLAVES'(1)));
  assign ack_one   = ack_any && !ack_multi;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_data = '0;
    sel_dov  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (ack[i]) begin
        sel_data = data_out[i*DATA_W +: DATA_W];
        sel_dov  = data_out_valid[i];
      end
    end
  end

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    tmo_next      = tmo_cnt;
    rsp_load      = 1'b0;
    rsp_data_next = '0;
    rsp_err_next  = ERR_OK;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tmo_next   = '0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_next = tmo_cnt + TMO_W'(1);
        if (ack_multi) begin
          rsp_load     = 1'b1;
          rsp_err_next = ERR_COLL;
          state_next   = S_RESP;
        end else if (ack_one && (!rd || sel_dov)) begin
          rsp_load      = 1'b1;
          rsp_data_next = rd ? sel_data : '0;
          state_next    = S_RESP;
        end else if (tmo_next == TMO_W'(TIMEOUT)) begin
          rsp_load     = 1'b1;
          rsp_err_next = ERR_TIMEOUT;
          state_next   = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= frame;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tmo_cnt   <= '0;
      valid     <= 1'b0;
      address   <= '0;
      data      <= '0;
      rd        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      tmo_cnt   <= tmo_next;
      valid     <= (state_next == S_WAIT);
      rsp_valid <= (state_next == S_RESP);
      overflow  <= frame_valid && !push;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (pop) begin
        rd      <= head[FRAME_W-1];
        address <= head[DATA_W +: ADDR_W];
        data    <= head[DATA_W-1:0];
      end
      if (rsp_load) begin
        rsp_data <= rsp_data_next;
        rsp_err  <= rsp_err_next;
      end
    end
  end

endmodule

// File: tb/tb_frame_bus_bridge.sv
// Directed bench for frame_bus_bridge: writes, reads, timeout, collision, FIFO overflow with
// back-to-back frames, and reset in the middle of a transaction.
module tb_frame_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic [8:0]  frame;
  logic [2:0]  ack;
  logic [11:0] data_out;
  logic [2:0]  data_out_valid;
  logic        valid;
  logic [3:0]  address;
  logic [3:0]  data;
  logic        rd;
  logic        rsp_valid;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_err;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int passed = 0;

  frame_bus_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .frame_valid    (frame_valid),
    .frame          (frame),
    .ack            (ack),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .valid          (valid),
    .address        (address),
    .data           (data),
    .rd             (rd),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic r, input logic [3:0] a, input logic [3:0] d);
    frame_valid = 1'b1;
    frame       = {r, a, d};
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (valid !== 1'b0)      $display("FAIL rst_valid: got %b want 0", valid);         else passed++;
    checks++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b want 0", busy);           else passed++;
    checks++; if (rsp_valid !== 1'b0)  $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (overflow !== 1'b0)   $display("FAIL rst_overflow: got %b want 0", overflow);   else passed++;
    checks++; if ({rsp_err, rsp_data, address, data, rd} !== 15'h0)
      $display("FAIL rst_outputs: got %h want 0", {rsp_err, rsp_data, address, data, rd});
    else passed++;
  endtask

  task automatic test_write;
    send_frame(1'b0, 4'h2, 4'hA);
    checks++; if (valid !== 1'b0) $display("FAIL wr_latency_early: got %b want 0", valid); else passed++;
    tick();
    checks++; if ({valid, rd, address, data} !== {1'b1, 1'b0, 4'h2, 4'hA})
      $display("FAIL wr_bus: got v=%b rd=%b a=%h d=%h want v=1 rd=0 a=2 d=a", valid, rd, address, data);
    else passed++;
    tick();
    tick();
    checks++; if (valid !== 1'b1) $display("FAIL wr_hold: got %b want 1", valid); else passed++;
    ack = 3'b010;
    tick();
    ack = 3'b000;
    checks++; if ({valid, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b1, 2'b00, 4'h0})
      $display("FAIL wr_rsp: got v=%b rv=%b err=%b d=%h want v=0 rv=1 err=00 d=0", valid, rsp_valid, rsp_err, rsp_data);
    else passed++;
    tick();
    checks++; if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL wr_rsp_one_cycle: got rv=%b busy=%b want 0 0", rsp_valid, busy);
    else passed++;
  endtask

  task automatic test_read;
    send_frame(1'b1, 4'h5, 4'h0);
    tick();
    checks++; if ({valid, rd, address} !== {1'b1, 1'b1, 4'h5})
      $display("FAIL rd_bus: got v=%b rd=%b a=%h want v=1 rd=1 a=5", valid, rd, address);
    else passed++;
    ack      = 3'b100;
    data_out = 12'h7C3;
    tick();
    checks++; if ({valid, rsp_valid} !== 2'b10)
      $display("FAIL rd_ack_without_data: got v=%b rv=%b want 1 0", valid, rsp_valid);
    else passed++;
    data_out_valid = 3'b100;
    tick();
    ack            = 3'b000;
    data_out_valid = 3'b000;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 2'b00, 4'h7})
      $display("FAIL rd_rsp: got rv=%b err=%b d=%h want rv=1 err=00 d=7", rsp_valid, rsp_err, rsp_data);
    else passed++;
    tick();
    checks++; if (rsp_data !== 4'h7) $display("FAIL rd_rsp_hold: got %h want 7", rsp_data); else passed++;
  endtask

  task automatic test_timeout;
    int high_cycles;
    send_frame(1'b0, 4'h3, 4'h1);
    tick();
    high_cycles = 0;
    while (valid && high_cycles < 40) begin
      high_cycles++;
      tick();
    end
    checks++; if (high_cycles !== 16) $display("FAIL tmo_cycles: got %0d want 16", high_cycles); else passed++;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 2'b01, 4'h0})
      $display("FAIL tmo_rsp: got rv=%b err=%b d=%h want rv=1 err=01 d=0", rsp_valid, rsp_err, rsp_data);
    else passed++;
    tick();
    checks++; if ({busy, valid} !== 2'b00) $display("FAIL tmo_idle: got busy=%b v=%b want 0 0", busy, valid); else passed++;
  endtask

  task automatic test_collision;
    send_frame(1'b1, 4'h6, 4'h0);
    tick();
    ack            = 3'b011;
    data_out_valid = 3'b011;
    data_out       = 12'h0F9;
    tick();
    ack            = 3'b000;
    data_out_valid = 3'b000;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 2'b10, 4'h0})
      $display("FAIL coll_rsp: got rv=%b err=%b d=%h want rv=1 err=10 d=0", rsp_valid, rsp_err, rsp_data);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    int waited;
    logic [3:0] exp_a, exp_d;
    for (int i = 0; i < 6; i++) begin
      frame_valid = 1'b1;
      exp_a       = 4'(i + 1);
      exp_d       = 4'(i + 8);
      frame       = {1'b0, exp_a, exp_d};
      tick();
      checks++; if (overflow !== (i == 5))
        $display("FAIL b2b_overflow_%0d: got %b want %b", i, overflow, (i == 5));
      else passed++;
    end
    frame_valid = 1'b0;
    tick();
    checks++; if ({overflow, busy} !== 2'b01)
      $display("FAIL b2b_overflow_pulse: got ovf=%b busy=%b want 0 1", overflow, busy);
    else passed++;
    for (int j = 0; j < 5; j++) begin
      waited = 0;
      while (!valid && waited < 10) begin
        tick();
        waited++;
      end
      exp_a = 4'(j + 1);
      exp_d = 4'(j + 8);
      checks++; if ({valid, address, data} !== {1'b1, exp_a, exp_d})
        $display("FAIL b2b_order_%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h", j, valid, address, data, exp_a, exp_d);
      else passed++;
      if (j > 0) begin
        checks++; if (waited !== 2) $display("FAIL b2b_gap_%0d: got %0d want 2", j, waited); else passed++;
      end
      ack = 3'b001;
      tick();
      ack = 3'b000;
      checks++; if ({rsp_valid, rsp_err} !== {1'b1, 2'b00})
        $display("FAIL b2b_rsp_%0d: got rv=%b err=%b want rv=1 err=00", j, rsp_valid, rsp_err);
      else passed++;
    end
    tick();
    tick();
    checks++; if ({busy, valid} !== 2'b00)
      $display("FAIL b2b_drained: got busy=%b v=%b want 0 0", busy, valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int rsp_seen;
    for (int i = 0; i < 3; i++) begin
      frame_valid = 1'b1;
      frame       = {1'b0, 4'(i + 10), 4'h1};
      tick();
    end
    frame_valid = 1'b0;
    checks++; if ({valid, busy} !== 2'b11) $display("FAIL mid_in_wait: got v=%b busy=%b want 1 1", valid, busy); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({valid, busy, rsp_valid} !== 3'b000)
      $display("FAIL mid_rst: got v=%b busy=%b rv=%b want 0 0 0", valid, busy, rsp_valid);
    else passed++;
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || valid) rsp_seen++;
    end
    checks++; if (rsp_seen !== 0) $display("FAIL mid_quiet: got %0d active cycles want 0", rsp_seen); else passed++;
    send_frame(1'b0, 4'hE, 4'h5);
    tick();
    checks++; if ({valid, address, data} !== {1'b1, 4'hE, 4'h5})
      $display("FAIL mid_new_bus: got v=%b a=%h d=%h want v=1 a=e d=5", valid, address, data);
    else passed++;
    ack = 3'b001;
    tick();
    ack = 3'b000;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 2'b00, 4'h0})
      $display("FAIL mid_new_rsp: got rv=%b err=%b d=%h want rv=1 err=00 d=0", rsp_valid, rsp_err, rsp_data);
    else passed++;
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    frame_valid    = 1'b0;
    frame          = '0;
    ack            = '0;
    data_out       = '0;
    data_out_valid = '0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
